// File: rtl/ft245_pkg.sv
// Shared FSM encoding and default timing for the FT245 synchronous-FIFO bridge.
package ft245_pkg;

    localparam int RD_PULSE_DEF = 4;
    localparam int WR_PULSE_DEF = 4;
    localparam int RECOVER_DEF  = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RECOVER
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ft245_bridge_if.sv
// SOC byte streams plus FT245 pin-side bus, bundled for the bridge.
interface ft245_bridge_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       pin_txe_n;
    logic       pin_rxf_n;
    logic [7:0] pin_din;
    logic [7:0] pin_dout;
    logic       pin_oe;
    logic       pin_rd;
    logic       pin_wr;

    modport slave (
        input  tx_data, tx_valid, rx_ready, pin_txe_n, pin_rxf_n, pin_din,
        output tx_ready, rx_data, rx_valid, pin_dout, pin_oe, pin_rd, pin_wr
    );

    modport master (
        output tx_data, tx_valid, rx_ready, pin_txe_n, pin_rxf_n, pin_din,
        input  tx_ready, rx_data, rx_valid, pin_dout, pin_oe, pin_rd, pin_wr
    );
endinterface

// File: rtl/byte_fifo.sv
// Small byte FIFO: show-ahead head, overflow/underflow requests dropped.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/ft245_bridge.sv
// FT245 bridge: round-robin read/write strobe sequencer between SOC FIFOs and host pins.
module ft245_bridge #(
    parameter int RD_PULSE = ft245_pkg::RD_PULSE_DEF,
    parameter int WR_PULSE = ft245_pkg::WR_PULSE_DEF,
    parameter int RECOVER  = ft245_pkg::RECOVER_DEF,
    parameter int DEPTH    = 4
) (
    input logic           clk,
    input logic           reset,
    ft245_bridge_if.slave bus
);
    import ft245_pkg::state_e;
    import ft245_pkg::IDLE;
    import ft245_pkg::RD_STROBE;
    import ft245_pkg::WR_SETUP;
    import ft245_pkg::WR_STROBE;
    import ft245_pkg::WR_HOLD;
    import ft245_pkg::max3;

    localparam int CNT_W = $clog2(max3(RD_PULSE, WR_PULSE, RECOVER)) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_wr_q, last_wr_d;

    logic [7:0] tx_head;
    logic       tx_full, tx_empty, tx_pop;
    logic       rx_full, rx_empty, rx_push;
    logic       rd_req, wr_req;
    logic       rd_last, wr_last, rec_last;

    assign rd_req   = !bus.pin_rxf_n && !rx_full;
    assign wr_req   = !bus.pin_txe_n && !tx_empty;
    assign rd_last  = (cnt_q == CNT_W'(RD_PULSE - 1));
    assign wr_last  = (cnt_q == CNT_W'(WR_PULSE - 1));
    assign rec_last = (cnt_q == CNT_W'(RECOVER - 1));

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push_i(bus.tx_valid && bus.tx_ready), .din_i(bus.tx_data),
        .pop_i(tx_pop), .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push_i(rx_push), .din_i(bus.pin_din),
        .pop_i(bus.rx_valid && bus.rx_ready), .dout_o(bus.rx_data),
        .full_o(rx_full), .empty_o(rx_empty)
    );

    assign bus.tx_ready = !tx_full;
    assign bus.rx_valid = !rx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                // On a tie, serve whichever direction went last time's opposite.
                if (rd_req && (!wr_req || last_wr_q)) begin
                    state_d   = RD_STROBE;
                    last_wr_d = 1'b0;
                end else if (wr_req) begin
                    state_d   = WR_SETUP;
                    last_wr_d = 1'b1;
                end
            end
            RD_STROBE: begin
                if (rd_last) state_d = ft245_pkg::RECOVER;
                else         cnt_d   = cnt_q + CNT_W'(1);
            end
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: begin
                if (wr_last) state_d = WR_HOLD;
                else         cnt_d   = cnt_q + CNT_W'(1);
            end
            WR_HOLD:   state_d = ft245_pkg::RECOVER;
            ft245_pkg::RECOVER: begin
                if (rec_last) state_d = IDLE;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pin_rd   = (state_q == RD_STROBE);
        bus.pin_wr   = (state_q == WR_STROBE);
        bus.pin_oe   = (state_q == WR_SETUP) || (state_q == WR_STROBE) || (state_q == WR_HOLD);
        bus.pin_dout = bus.pin_oe ? tx_head : 8'h00;
        rx_push      = (state_q == RD_STROBE) && rd_last;
        tx_pop       = (state_q == WR_HOLD);
    end
endmodule

// File: doc/ft245_bridge.md
FT245_BRIDGE -- requirements
Module: ft245_bridge

Interface
REQ-001 Parameter RD_PULSE, default 4: rd assert width in clk cycles, minimum 2.
REQ-002 Parameter WR_PULSE, default 4: wr assert width in clk cycles, minimum 1.
REQ-003 Parameter RECOVER, default 2: idle cycles after each transfer, minimum 1.
REQ-004 Parameter DEPTH, default 4: entries in each of the TX and RX FIFOs, a power of 2, minimum 2.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 tx_data  in  8  byte from SOC to host.
REQ-008 tx_valid  in  1  tx_data valid; a byte is accepted when tx_valid and tx_ready are both high.
REQ-009 tx_ready  out  1  TX FIFO not full.
REQ-010 rx_data  out  8  byte from host to SOC.
REQ-011 rx_valid  out  1  RX FIFO not empty.
REQ-012 rx_ready  in  1  SOC pops a byte when rx_valid and rx_ready are both high.
REQ-013 pin_txe_n  in  1  FT245 TXE#, already synchronized; low means the host FIFO can accept a byte.
REQ-014 pin_rxf_n  in  1  FT245 RXF#, already synchronized; low means the host FIFO holds a byte.
REQ-015 pin_din  in  8  data bus input.
REQ-016 pin_dout  out  8  data bus drive value.
REQ-017 pin_oe  out  1  bus output enable; the top level tristates the bus when this is low.
REQ-018 pin_rd  out  1  active-high read strobe; the top level inverts it to RD#.
REQ-019 pin_wr  out  1  active-high write strobe; the top level inverts it to WR.

Function
REQ-020 The FSM SHALL have states IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD and RECOVER.
REQ-021 IDLE SHALL grant a read when rd_req = !pin_rxf_n and RX FIFO not full.
REQ-022 IDLE SHALL grant a write when wr_req = !pin_txe_n and TX FIFO not empty.
REQ-023 When both requests are present, IDLE SHALL grant the direction not served last (round-robin); after reset the last-served direction is write, so read wins the first tie.
REQ-024 RD_STROBE SHALL hold pin_rd=1 for exactly RD_PULSE cycles.
REQ-025 On the last RD_STROBE cycle, pin_din SHALL be pushed into the RX FIFO; the FSM then enters RECOVER.
REQ-026 WR_SETUP SHALL last 1 cycle, with pin_oe=1, pin_dout = TX FIFO head and pin_wr=0.
REQ-027 WR_STROBE SHALL hold pin_wr=1 for exactly WR_PULSE cycles.
REQ-028 WR_HOLD SHALL last 1 cycle, with pin_wr=0 and pin_oe=1; the TX FIFO pops in this cycle; the FSM then enters RECOVER.
REQ-029 pin_oe SHALL be 1 only in WR_SETUP, WR_STROBE and WR_HOLD; pin_oe and pin_rd SHALL never both be 1.
REQ-030 pin_dout SHALL stay stable from WR_SETUP through WR_HOLD.
REQ-031 RECOVER SHALL hold pin_rd=0, pin_wr=0 and pin_oe=0 for RECOVER cycles, then return to IDLE.
REQ-032 Once a transfer is granted it SHALL complete even if pin_txe_n or pin_rxf_n changes mid-transfer.
REQ-033 Peak throughput SHALL be one read per RD_PULSE+RECOVER+1 cycles (1 = IDLE) and one write per WR_PULSE+RECOVER+3 cycles (3 = IDLE, WR_SETUP, WR_HOLD).
REQ-034 FIFO push and pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-035 Push on full and pop on empty SHALL be ignored; read and write pointers wrap modulo DEPTH.
REQ-036 The RX FIFO full flag SHALL block new read grants only; a read already in flight always has room, because fullness is checked at grant time.
REQ-037 rx_data SHALL show the RX FIFO head combinationally whenever rx_valid=1.
REQ-038 The FIFO occupancy counter SHALL be clog2(DEPTH)+1 bits wide; the strobe counter SHALL be clog2(max(RD_PULSE,WR_PULSE,RECOVER))+1 bits wide.

Reset
REQ-039 Reset SHALL force state IDLE, both FIFOs empty, pin_rd=0, pin_wr=0, pin_oe=0, pin_dout=0, tx_ready=1 and rx_valid=0.
REQ-040 Reset asserted mid-strobe SHALL drop the strobe and pin_oe on the next edge; the partial byte is discarded.

Structure
REQ-041 Package ft245_pkg SHALL hold the FSM state enum and the default values of RD_PULSE, WR_PULSE and RECOVER.
REQ-042 One sub-module, byte_fifo (parameter DEPTH), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-043 Single read: pin_rxf_n=0, pin_din=0xA5 -> pin_rd high for 4 cycles, then rx_valid=1 with rx_data=0xA5.
REQ-044 Single write: push 0x3C with pin_txe_n=0 -> pin_oe rises 1 cycle before pin_wr, pin_wr high for 4 cycles, pin_dout=0x3C throughout, pin_oe falls 1 cycle after pin_wr.
REQ-045 Contention: rxf and txe both active with the TX FIFO non-empty -> transfers alternate read, write, read; pin_oe and pin_rd are never both high.
REQ-046 Back-pressure: rx_ready=0 with 5 host bytes pending -> exactly 4 reads occur, then pin_rd stays 0; one pop leads to exactly one more read.
REQ-047 Reset mid-transfer: assert reset during the 2nd WR_STROBE cycle -> next edge shows pin_wr=0, pin_oe=0, tx_ready=1 and state IDLE.
